// File: rtl/spireg_pkg.sv
// rtl/spireg_pkg.sv - shared address map and fast command codes for spireg
package spireg_pkg;

   localparam int SPIREG_ADDR_CTRL = 0;
   localparam int SPIREG_ADDR_EVT  = 1;
   localparam int SPIREG_ADDR_IEN  = 2;

   localparam logic [5:0] SPIREG_FC_EVT_CLR = 6'd63;
   localparam logic [5:0] SPIREG_FC_RSVD    = 6'd62;

   typedef enum logic [1:0] {
      FC_NOP,
      FC_CTRL_BIT,
      FC_EVT_CLR
   } spireg_fc_e;

   // Codes 0..61 address CTRL bit code>>1 with value code[0].
   function automatic spireg_fc_e spireg_fc_decode(input logic vld, input logic [5:0] code);
      if (!vld)                          return FC_NOP;
      else if (code == SPIREG_FC_EVT_CLR) return FC_EVT_CLR;
      else if (code == SPIREG_FC_RSVD)    return FC_NOP;
      else                                return FC_CTRL_BIT;
   endfunction

endpackage

// File: rtl/spireg_regfile_if.sv
// rtl/spireg_regfile_if.sv - register/fastcmd bus between spireg and its register file
interface spireg_regfile_if #(
   parameter int ADDR_W = 3,
   parameter int REG_W  = 16
);
   logic [ADDR_W-1:0] reg_addr;
   logic [REG_W-1:0]  reg_data_i;
   logic [REG_W-1:0]  reg_data_o;
   logic              reg_data_o_vld;
   logic [7:0]        status;
   logic [5:0]        fastcmd;
   logic              fastcmd_vld;

   modport master (
      output reg_addr, reg_data_o, reg_data_o_vld, fastcmd, fastcmd_vld,
      input  reg_data_i, status
   );

   modport slave (
      input  reg_addr, reg_data_o, reg_data_o_vld, fastcmd, fastcmd_vld,
      output reg_data_i, status
   );
endinterface

// File: rtl/spireg_evt.sv
// rtl/spireg_evt.sv - sticky event bits with rising-edge set, W1C and clear-all
module spireg_evt
   import spireg_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic [W-1:0] evt_in,
   input  logic [W-1:0] w1c_mask,
   input  logic         clr_all,
   output logic [W-1:0] evt
);
   logic [W-1:0] evt_prev;
   logic [W-1:0] rise;

   assign rise = evt_in & ~evt_prev;

   // evt_prev resets high so inputs already high at release do not fire.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         evt_prev <= '1;
         evt      <= '0;
      end else begin
         evt_prev <= evt_in;
         evt      <= clr_all ? rise : ((evt & ~w1c_mask) | rise);
      end
   end
endmodule

// File: rtl/spireg_regfile.sv
// rtl/spireg_regfile.sv - parametrised register file behind spireg (CTRL, EVT, IEN, RW, RO)
module spireg_regfile
   import spireg_pkg::*;
#(
   parameter int               ADDR_W   = 3,
   parameter int               REG_W    = 16,
   parameter int               RO_BASE  = 4,
   parameter logic [REG_W-1:0] CTRL_RST = '0
) (
   input  logic                                      clk,
   input  logic                                      nrst,
   spireg_regfile_if.slave                           bus,
   input  logic [REG_W-1:0]                          evt_in,
   input  logic [((1 << ADDR_W) - RO_BASE)*REG_W-1:0] ro_data,
   output logic [RO_BASE*REG_W-1:0]                  rw_regs,
   output logic [(1 << ADDR_W)-1:0]                  wr_stb,
   output logic                                      irq
);
   localparam int N_REGS = 1 << ADDR_W;

   logic [REG_W-1:0]  rw_q     [RO_BASE];
   logic [REG_W-1:0]  all_regs [N_REGS];
   logic [REG_W-1:0]  evt;
   logic [REG_W-1:0]  ctrl_nxt;
   logic [REG_W-1:0]  w1c_mask;
   logic [N_REGS-1:0] wr_hit;
   spireg_fc_e        fc_op;

   assign fc_op = spireg_fc_decode(bus.fastcmd_vld, bus.fastcmd);

   always_comb begin
      wr_hit = '0;
      for (int a = 0; a < RO_BASE; a++) begin
         if (bus.reg_data_o_vld && bus.reg_addr == ADDR_W'(a)) wr_hit[a] = 1'b1;
      end
   end

   // fastcmd is applied after the bus write so it wins on a shared CTRL bit.
   always_comb begin
      ctrl_nxt = wr_hit[SPIREG_ADDR_CTRL] ? bus.reg_data_o : rw_q[SPIREG_ADDR_CTRL];
      for (int i = 0; i < REG_W; i++) begin
         if (fc_op == FC_CTRL_BIT && int'(bus.fastcmd[5:1]) == i) ctrl_nxt[i] = bus.fastcmd[0];
      end
   end

   assign w1c_mask = wr_hit[SPIREG_ADDR_EVT] ? bus.reg_data_o : '0;

   spireg_evt #(.W(REG_W)) u_evt (
      .clk      (clk),
      .nrst     (nrst),
      .evt_in   (evt_in),
      .w1c_mask (w1c_mask),
      .clr_all  (fc_op == FC_EVT_CLR),
      .evt      (evt)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rw_q[SPIREG_ADDR_CTRL] <= CTRL_RST;
         for (int a = 1; a < RO_BASE; a++) rw_q[a] <= '0;
         wr_stb <= '0;
         irq    <= 1'b0;
      end else begin
         rw_q[SPIREG_ADDR_CTRL] <= ctrl_nxt;
         for (int a = 2; a < RO_BASE; a++) begin
            if (wr_hit[a]) rw_q[a] <= bus.reg_data_o;
         end
         wr_stb <= wr_hit;
         irq    <= |(evt & rw_q[SPIREG_ADDR_IEN]);
      end
   end

   for (genvar g = 0; g < N_REGS; g++) begin : g_map
      if (g == SPIREG_ADDR_EVT) begin : g_evt
         assign all_regs[g] = evt;
      end else if (g < RO_BASE) begin : g_rw
         assign all_regs[g] = rw_q[g];
      end else begin : g_ro
         assign all_regs[g] = ro_data[(g-RO_BASE)*REG_W +: REG_W];
      end
      if (g < RO_BASE) begin : g_out
         assign rw_regs[g*REG_W +: REG_W] = all_regs[g];
      end
   end

   assign bus.reg_data_i = all_regs[bus.reg_addr];
   assign bus.status     = {irq, |evt, rw_q[SPIREG_ADDR_CTRL][5:0]};
endmodule

// File: tb/tb_spireg_regfile.sv
// tb/tb_spireg_regfile.sv - directed self-checking bench for spireg_regfile
`timescale 1ns/1ps
module tb_spireg_regfile;
   logic        clk;
   logic        nrst;
   logic [15:0] evt_in;
   logic [63:0] ro_data;
   logic [63:0] rw_regs;
   logic [7:0]  wr_stb;
   logic        irq;
   int          checks;
   int          errors;

   spireg_regfile_if #(.ADDR_W(3), .REG_W(16)) bus ();

   spireg_regfile #(
      .ADDR_W   (3),
      .REG_W    (16),
      .RO_BASE  (4),
      .CTRL_RST (16'h0081)
   ) dut (
      .clk     (clk),
      .nrst    (nrst),
      .bus     (bus),
      .evt_in  (evt_in),
      .ro_data (ro_data),
      .rw_regs (rw_regs),
      .wr_stb  (wr_stb),
      .irq     (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [2:0] addr, input logic [15:0] data);
      bus.reg_addr       = addr;
      bus.reg_data_o     = data;
      bus.reg_data_o_vld = 1'b1;
      tick();
      bus.reg_data_o_vld = 1'b0;
   endtask

   task automatic do_fc(input logic [5:0] code);
      bus.fastcmd     = code;
      bus.fastcmd_vld = 1'b1;
      tick();
      bus.fastcmd_vld = 1'b0;
   endtask

   task automatic test_reset();
      nrst               = 1'b0;
      evt_in             = 16'h0001;
      ro_data            = {16'h0000, 16'h0000, 16'hBEEF, 16'h0000};
      bus.reg_addr       = 3'd0;
      bus.reg_data_o     = 16'h0000;
      bus.reg_data_o_vld = 1'b0;
      bus.fastcmd        = 6'd0;
      bus.fastcmd_vld    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (rw_regs !== 64'h0000_0000_0000_0081) begin
         errors++; $display("FAIL reset_rw_regs got %h exp %h", rw_regs, 64'h81);
      end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
      checks++;
      if (wr_stb !== 8'h00) begin errors++; $display("FAIL reset_wr_stb got %h exp 00", wr_stb); end
      checks++;
      if (bus.status !== 8'h01) begin errors++; $display("FAIL reset_status got %h exp 01", bus.status); end
      @(negedge clk);
      nrst = 1'b1;
      tick();
      tick();
      checks++;
      if (rw_regs[31:16] !== 16'h0000) begin
         errors++; $display("FAIL reset_high_input_evt got %h exp 0000", rw_regs[31:16]);
      end
      evt_in = 16'h0000;
      tick();
   endtask

   task automatic test_rw_write();
      do_write(3'd3, 16'hA55A);
      checks++;
      if (wr_stb !== 8'b0000_1000) begin errors++; $display("FAIL rw_stb got %b exp 00001000", wr_stb); end
      checks++;
      if (bus.reg_data_i !== 16'hA55A) begin errors++; $display("FAIL rw_read got %h exp a55a", bus.reg_data_i); end
      checks++;
      if (rw_regs[63:48] !== 16'hA55A) begin errors++; $display("FAIL rw_flat got %h exp a55a", rw_regs[63:48]); end
      tick();
      checks++;
      if (wr_stb !== 8'h00) begin errors++; $display("FAIL rw_stb_one_cycle got %b exp 0", wr_stb); end
   endtask

   task automatic test_ro();
      do_write(3'd5, 16'h1234);
      checks++;
      if (wr_stb !== 8'h00) begin errors++; $display("FAIL ro_no_stb got %b exp 0", wr_stb); end
      checks++;
      if (bus.reg_data_i !== 16'hBEEF) begin errors++; $display("FAIL ro_read got %h exp beef", bus.reg_data_i); end
      bus.reg_addr = 3'd7;
      #1;
      checks++;
      if (bus.reg_data_i !== 16'h0000) begin errors++; $display("FAIL ro_read7 got %h exp 0000", bus.reg_data_i); end
   endtask

   task automatic test_fastcmd();
      do_write(3'd0, 16'h0000);
      checks++;
      if (wr_stb !== 8'h01) begin errors++; $display("FAIL ctrl_stb got %b exp 00000001", wr_stb); end
      do_fc(6'd5);
      checks++;
      if (rw_regs[15:0] !== 16'h0004) begin errors++; $display("FAIL fc5 got %h exp 0004", rw_regs[15:0]); end
      checks++;
      if (bus.status !== 8'h04) begin errors++; $display("FAIL fc5_status got %h exp 04", bus.status); end
      do_fc(6'd4);
      checks++;
      if (rw_regs[15:0] !== 16'h0000) begin errors++; $display("FAIL fc4 got %h exp 0000", rw_regs[15:0]); end
      do_fc(6'd31);
      checks++;
      if (rw_regs[15:0] !== 16'h8000) begin errors++; $display("FAIL fc31 got %h exp 8000", rw_regs[15:0]); end
      do_fc(6'd40);
      checks++;
      if (rw_regs[15:0] !== 16'h8000) begin errors++; $display("FAIL fc40 got %h exp 8000", rw_regs[15:0]); end
      do_fc(6'd62);
      checks++;
      if (rw_regs[15:0] !== 16'h8000) begin errors++; $display("FAIL fc62 got %h exp 8000", rw_regs[15:0]); end
      do_fc(6'd30);
      checks++;
      if (rw_regs[15:0] !== 16'h0000) begin errors++; $display("FAIL fc30 got %h exp 0000", rw_regs[15:0]); end
   endtask

   task automatic test_events();
      do_write(3'd2, 16'h0008);
      evt_in = 16'h0008;
      tick();
      checks++;
      if (rw_regs[31:16] !== 16'h0008) begin errors++; $display("FAIL evt_set got %h exp 0008", rw_regs[31:16]); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_latency got %b exp 0", irq); end
      tick();
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got %b exp 1", irq); end
      checks++;
      if (bus.status !== 8'hC0) begin errors++; $display("FAIL irq_status got %h exp c0", bus.status); end
      do_write(3'd1, 16'h0008);
      checks++;
      if (rw_regs[31:16] !== 16'h0000 || wr_stb !== 8'h02) begin
         errors++; $display("FAIL w1c got evt %h stb %b exp 0000 00000010", rw_regs[31:16], wr_stb);
      end
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold got %b exp 1", irq); end
      tick();
      checks++;
      if (irq !== 1'b0 || rw_regs[31:16] !== 16'h0000) begin
         errors++; $display("FAIL irq_fall_level got irq %b evt %h exp 0 0000", irq, rw_regs[31:16]);
      end
      evt_in = 16'h0000;
      tick();
      evt_in = 16'h0008;
      tick();
      evt_in = 16'h0000;
      tick();
      checks++;
      if (rw_regs[31:16] !== 16'h0008) begin errors++; $display("FAIL evt_sticky got %h exp 0008", rw_regs[31:16]); end
      evt_in = 16'h0008;
      do_write(3'd1, 16'h0008);
      checks++;
      if (rw_regs[31:16] !== 16'h0008) begin errors++; $display("FAIL set_wins got %h exp 0008", rw_regs[31:16]); end
      do_write(3'd1, 16'h0008);
      do_write(3'd2, 16'h0000);
      tick();
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL ien_off got %b exp 0", irq); end
   endtask

   task automatic test_same_cycle();
      bus.fastcmd     = 6'd1;
      bus.fastcmd_vld = 1'b1;
      do_write(3'd0, 16'h0000);
      bus.fastcmd_vld = 1'b0;
      checks++;
      if (rw_regs[15:0] !== 16'h0001 || wr_stb !== 8'h01) begin
         errors++; $display("FAIL fc_vs_write got ctrl %h stb %b exp 0001 00000001", rw_regs[15:0], wr_stb);
      end
   endtask

   task automatic test_clr_all();
      evt_in = 16'h00F8;
      tick();
      checks++;
      if (rw_regs[31:16] !== 16'h00F0) begin errors++; $display("FAIL evt_f0 got %h exp 00f0", rw_regs[31:16]); end
      do_fc(6'd63);
      checks++;
      if (rw_regs[31:16] !== 16'h0000) begin errors++; $display("FAIL fc63 got %h exp 0000", rw_regs[31:16]); end
      evt_in = 16'h0000;
      tick();
      evt_in = 16'h0003;
      bus.fastcmd     = 6'd63;
      bus.fastcmd_vld = 1'b1;
      do_write(3'd1, 16'h0001);
      bus.fastcmd_vld = 1'b0;
      checks++;
      if (rw_regs[31:16] !== 16'h0003) begin errors++; $display("FAIL fc63_rise got %h exp 0003", rw_regs[31:16]); end
   endtask

   task automatic test_mid_reset();
      evt_in = 16'h0103;
      @(posedge clk);
      #2;
      nrst = 1'b0;
      #1;
      checks++;
      if (rw_regs !== 64'h0000_0000_0000_0081 || wr_stb !== 8'h00 || irq !== 1'b0) begin
         errors++; $display("FAIL mid_reset got rw %h stb %b irq %b exp 81 0 0", rw_regs, wr_stb, irq);
      end
      @(negedge clk);
      nrst = 1'b1;
      tick();
      checks++;
      if (rw_regs[31:16] !== 16'h0000) begin errors++; $display("FAIL post_reset_evt got %h exp 0000", rw_regs[31:16]); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_rw_write();
      test_ro();
      test_fastcmd();
      test_events();
      test_same_cycle();
      test_clr_all();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
